// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer and DataPath: the instruction and
// memory status the sequencer consumes, and every strobe it produces.
interface control_sequencer_if #(
    parameter int unsigned NREGS = 16
);
    // sequencer inputs
    logic             run;
    logic [31:0]      ir;
    logic             mem_ready;

    // bus drive enables
    logic             PCout;
    logic             Zlo_out;
    logic             MDRout;

    // register load enables
    logic             MARin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             Zin;

    // ALU and memory controls
    logic             IncPC;
    logic             Read;
    logic [4:0]       opcode;

    // general-purpose register file select lines
    logic [NREGS-1:0] reg_out;
    logic [NREGS-1:0] reg_in;

    // status
    logic             halted;
    logic             illegal_op;
    logic             mem_timeout;

    modport master (
        input  run, ir, mem_ready,
        output PCout, Zlo_out, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin,
        output IncPC, Read, opcode,
        output reg_out, reg_in,
        output halted, illegal_op, mem_timeout
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, Zlo_out, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin,
        input  IncPC, Read, opcode,
        input  reg_out, reg_in,
        input  halted, illegal_op, mem_timeout
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit for DataPath: fetch (T0-T2), then decode IR and run
// three-register ALU, two-register unary, nop and halt instructions.
// Strobes are Moore outputs of the step state, plus IR fields in T3-T5.
module control_sequencer #(
    parameter int unsigned FETCH_WAIT_MAX = 15,
    parameter int unsigned NREGS          = 16
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    localparam int unsigned CW = (FETCH_WAIT_MAX < 1) ? 1 : $clog2(FETCH_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_SHR  = 5'b00111,
        OP_SHRA = 5'b01000,
        OP_SHL  = 5'b01001,
        OP_ROR  = 5'b01010,
        OP_ROL  = 5'b01011,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010,
        OP_NOP  = 5'b11010,
        OP_HALT = 5'b11011
    } op_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout_flag;
    logic          timeout_hit;

    logic [4:0]    op;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic          unused_ir;

    logic          is_alu3;
    logic          is_unary;
    logic          is_nop;
    logic          is_halt;
    logic          is_illegal;

    logic             pc_out;
    logic             zlo_out;
    logic             mdr_out;
    logic             mar_in;
    logic             pc_in;
    logic             mdr_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             inc_pc;
    logic             mem_read;
    logic [4:0]       alu_op;
    logic [NREGS-1:0] gpr_out;
    logic [NREGS-1:0] gpr_in;
    logic             illegal;

    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    // the last T1 wait cycle that may still see mem_ready before giving up
    assign timeout_hit = (state == S_T1) && !bus.mem_ready
                         && (wait_cnt == CW'(FETCH_WAIT_MAX - 1));

    // one-hot register select; indices beyond NREGS select nothing
    function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            v[i] = (32'(idx) == i);
        end
        return v;
    endfunction

    // classify the current IR opcode into the instruction families
    always_comb begin
        is_alu3  = 1'b0;
        is_unary = 1'b0;
        is_nop   = 1'b0;
        is_halt  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_alu3  = 1'b1;
            OP_NEG, OP_NOT:                  is_unary = 1'b1;
            OP_NOP:                          is_nop   = 1'b1;
            OP_HALT:                         is_halt  = 1'b1;
            default:                         ;
        endcase
        is_illegal = !(is_alu3 || is_unary || is_nop || is_halt);
    end

    // step state register
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // T1 wait counter (zero outside T1, so its zero value marks the first T1 cycle) and sticky timeout
    always_ff @(posedge clock) begin
        if (clear) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == S_T1 && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    // next-step selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (bus.run) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1: begin
                if (bus.mem_ready) begin
                    state_next = S_T2;
                end else if (timeout_hit) begin
                    state_next = S_HALT;
                end
            end
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (is_alu3 || is_unary) begin
                    state_next = S_T4;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    state_next = bus.run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    state_next = S_T5;
                end else begin
                    state_next = bus.run ? S_T0 : S_IDLE;
                end
            end
            S_T5:   state_next = bus.run ? S_T0 : S_IDLE;
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // strobe decode from the current step and IR fields
    always_comb begin
        pc_out   = 1'b0;
        zlo_out  = 1'b0;
        mdr_out  = 1'b0;
        mar_in   = 1'b0;
        pc_in    = 1'b0;
        mdr_in   = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        alu_op   = '0;
        gpr_out  = '0;
        gpr_in   = '0;
        illegal  = 1'b0;
        case (state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlo_out  = 1'b1;
                pc_in    = (wait_cnt == '0);
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_alu3) begin
                    gpr_out = reg_sel(rb);
                    y_in    = 1'b1;
                end else if (is_unary) begin
                    gpr_out = reg_sel(rb);
                    alu_op  = op;
                    z_in    = 1'b1;
                end else if (is_illegal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    gpr_out = reg_sel(rc);
                    alu_op  = op;
                    z_in    = 1'b1;
                end else if (is_unary) begin
                    zlo_out = 1'b1;
                    gpr_in  = reg_sel(ra);
                end
            end
            S_T5: begin
                if (is_alu3) begin
                    zlo_out = 1'b1;
                    gpr_in  = reg_sel(ra);
                end
            end
            default: ;
        endcase
    end

    assign bus.PCout       = pc_out;
    assign bus.Zlo_out     = zlo_out;
    assign bus.MDRout      = mdr_out;
    assign bus.MARin       = mar_in;
    assign bus.PCin        = pc_in;
    assign bus.MDRin       = mdr_in;
    assign bus.IRin        = ir_in;
    assign bus.Yin         = y_in;
    assign bus.Zin         = z_in;
    assign bus.IncPC       = inc_pc;
    assign bus.Read        = mem_read;
    assign bus.opcode      = alu_op;
    assign bus.reg_out     = gpr_out;
    assign bus.reg_in      = gpr_in;
    assign bus.halted      = (state == S_HALT);
    assign bus.illegal_op  = illegal;
    assign bus.mem_timeout = timeout_flag;

endmodule
